// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches 16-bit instructions, decodes them
// into datapath control words, and sequences PC update, branches, stores
// and halt.  All outputs are decoded from registered state only.
module control_sequencer #(
  parameter int              PC_W     = 8,
  parameter int              EX_CYC   = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [15:0]     Instr,
  input  logic            V,
  input  logic            C,
  input  logic            N,
  input  logic            Z,
  output logic [PC_W-1:0] Iaddr,
  output logic [15:0]     CTRWRD,
  output logic [15:0]     Cin,
  output logic            MW,
  output logic            Halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [3:0]      r_cnt;
  logic            r_zf, r_nf;

  logic [3:0]      w_op;
  logic [2:0]      w_dr, w_sa, w_sb;
  logic [15:0]     w_cw;
  logic            w_wr, w_st, w_taken, w_last;
  logic [8:0]      w_off9;
  logic [PC_W-1:0] w_off;

  // V and C are reserved flags; folded here so they are visibly consumed.
  logic w_unused_flags;
  assign w_unused_flags = ^{V, C};

  assign w_op   = r_ir[15:12];
  assign w_dr   = r_ir[11:9];
  assign w_sa   = r_ir[8:6];
  assign w_sb   = r_ir[5:3];
  assign w_off9 = {r_ir[11:9], r_ir[5:0]};
  assign w_off  = PC_W'($signed(w_off9));
  assign w_last = (r_cnt == 4'(EX_CYC - 1));
  assign Iaddr  = r_pc;

  // Decode IR into a control word (RW left clear) plus write/store/branch intent.
  always_comb begin
    w_cw    = '0;
    w_wr    = 1'b0;
    w_st    = 1'b0;
    w_taken = 1'b0;
    case (w_op)
      4'h1: begin w_cw = {w_dr, w_sa, w_sb, 1'b0, 4'b0000, 2'b00}; w_wr = 1'b1; end
      4'h2: begin w_cw = {w_dr, w_sa, w_sb, 1'b0, 4'b0010, 2'b00}; w_wr = 1'b1; end
      4'h3: begin w_cw = {w_dr, w_sa, w_sb, 1'b0, 4'b0101, 2'b00}; w_wr = 1'b1; end
      4'h4: begin w_cw = {w_dr, w_sa, w_sb, 1'b0, 4'b1000, 2'b00}; w_wr = 1'b1; end
      4'h5: begin w_cw = {w_dr, w_sa, w_sb, 1'b0, 4'b1001, 2'b00}; w_wr = 1'b1; end
      4'h6: begin w_cw = {w_dr, w_sa, w_sb, 1'b0, 4'b1010, 2'b00}; w_wr = 1'b1; end
      4'h7: begin w_cw = {w_dr, w_sa, w_sb, 1'b0, 4'b1011, 2'b00}; w_wr = 1'b1; end
      4'h8: begin w_cw = {w_dr, w_sa, 3'b000, 1'b1, 4'b0010, 2'b00}; w_wr = 1'b1; end
      4'h9: begin w_cw = {w_dr, w_sa, 3'b000, 1'b0, 4'b0000, 2'b10}; w_wr = 1'b1; end
      4'hA: begin w_cw = {3'b000, w_sa, w_sb, 1'b0, 4'b0000, 2'b00}; w_st = 1'b1; end
      4'hB: begin w_cw = {w_dr, 6'b000000, 1'b1, 4'b1100, 2'b00}; w_wr = 1'b1; end
      4'hC: begin w_cw = {3'b000, w_sa, 10'b0}; w_taken = r_zf; end
      4'hD: begin w_cw = {3'b000, w_sa, 10'b0}; w_taken = r_nf; end
      4'hE: w_taken = 1'b1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next state and registered-state-only output decode.
  always_comb begin
    w_state_nxt = r_state;
    CTRWRD      = '0;
    Cin         = '0;
    MW          = 1'b0;
    Halted      = 1'b0;
    case (r_state)
      S_FETCH: w_state_nxt = (Instr[15:12] == 4'hF) ? S_HALT : S_EXEC;
      S_EXEC: begin
        CTRWRD = w_cw;
        Cin    = {10'b0, r_ir[5:0]};
        if (w_last) w_state_nxt = S_WB;
      end
      S_WB: begin
        CTRWRD      = w_cw | {15'b0, w_wr};
        Cin         = {10'b0, r_ir[5:0]};
        MW          = w_st;
        w_state_nxt = S_FETCH;
      end
      S_HALT: Halted = 1'b1;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // IR latch, hold counter, flag capture on the last EXEC cycle, PC update in WB.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_pc  <= RESET_PC;
      r_ir  <= '0;
      r_cnt <= '0;
      r_zf  <= 1'b0;
      r_nf  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir  <= Instr;
          r_cnt <= '0;
        end
        S_EXEC: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_zf <= Z;
            r_nf <= N;
          end
        end
        S_WB: r_pc <= w_taken ? (r_pc + w_off) : (r_pc + PC_W'(1));
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a table of instructions is run back to back,
// each cycle's expected outputs are queued when driven and compared at the
// following falling edge; hand sequences cover halt and mid-EXEC reset.
module tb_control_sequencer;
  localparam int EX_CYC = 2;

  typedef struct {
    logic [15:0] ctr;
    logic [15:0] cin;
    logic        mw;
    logic        halted;
    logic [7:0]  iaddr;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    logic [1:0]  z;     // Z per EXEC cycle, bit 0 = first
    logic [1:0]  n;
    logic [15:0] ex;
    logic [15:0] wb;
    logic [15:0] cin;
    logic        mw;
    logic [7:0]  pc;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] Instr = '0;
  logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0;
  logic [7:0]  Iaddr;
  logic [15:0] CTRWRD, Cin;
  logic        MW, Halted;

  control_sequencer #(.PC_W(8), .EX_CYC(EX_CYC), .RESET_PC(8'h00)) dut (
    .CLK(CLK), .RESET(RESET), .Instr(Instr), .V(V), .C(C), .N(N), .Z(Z),
    .Iaddr(Iaddr), .CTRWRD(CTRWRD), .Cin(Cin), .MW(MW), .Halted(Halted)
  );

  always #5 CLK = ~CLK;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[18];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: pop the expectation for the cycle being observed.
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("CTRWRD", CTRWRD, e.ctr);
      chk("Cin", Cin, e.cin);
      chk("MW", {15'b0, MW}, {15'b0, e.mw});
      chk("Halted", {15'b0, Halted}, {15'b0, e.halted});
      chk("Iaddr", {8'b0, Iaddr}, {8'b0, e.iaddr});
    end
  end

  function automatic exp_t mk(input logic [15:0] ctr, input logic [15:0] cin,
                              input logic mw, input logic h, input logic [7:0] pc);
    exp_t e;
    e.ctr = ctr; e.cin = cin; e.mw = mw; e.halted = h; e.iaddr = pc;
    return e;
  endfunction

  task automatic step(input logic rst, input logic [15:0] ins, input logic z,
                      input logic n, input exp_t e);
    q.push_back(e);
    RESET = rst;
    Instr = ins;
    Z = z;
    N = n;
    V = 1'($urandom);
    C = 1'($urandom);
    @(posedge CLK);
    #1;
  endtask

  // One instruction: FETCH, EX_CYC EXEC cycles, WB. Instr is scrambled after FETCH.
  task automatic run_vec(input vec_t v);
    step(1'b1, v.instr, 1'b0, 1'b0, mk(16'h0, 16'h0, 1'b0, 1'b0, v.pc));
    for (int i = 0; i < EX_CYC; i++)
      step(1'b1, 16'($urandom), v.z[i], v.n[i], mk(v.ex, v.cin, 1'b0, 1'b0, v.pc));
    step(1'b1, 16'($urandom), 1'($urandom), 1'($urandom), mk(v.wb, v.cin, v.mw, 1'b0, v.pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          instr    z      n      ex       wb       cin      mw    pc
    tbl[0]  = '{16'h2650, 2'b00, 2'b00, 16'h6508, 16'h6509, 16'h0010, 1'b0, 8'h00}; // ADD
    tbl[1]  = '{16'hBA2A, 2'b00, 2'b00, 16'hA070, 16'hA071, 16'h002A, 1'b0, 8'h01}; // LDI
    tbl[2]  = '{16'hA0D0, 2'b00, 2'b00, 16'h0D00, 16'h0D00, 16'h0010, 1'b1, 8'h02}; // ST
    tbl[3]  = '{16'hE002, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0002, 1'b0, 8'h03}; // JMP +2
    tbl[4]  = '{16'hCE3D, 2'b10, 2'b00, 16'h0000, 16'h0000, 16'h003D, 1'b0, 8'h05}; // BRZ taken
    tbl[5]  = '{16'hE003, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0003, 1'b0, 8'h02}; // JMP +3
    tbl[6]  = '{16'hCE3D, 2'b00, 2'b11, 16'h0000, 16'h0000, 16'h003D, 1'b0, 8'h05}; // BRZ not taken
    tbl[7]  = '{16'hEE3F, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h003F, 1'b0, 8'h06}; // JMP -1
    tbl[8]  = '{16'hCE3D, 2'b01, 2'b00, 16'h0000, 16'h0000, 16'h003D, 1'b0, 8'h05}; // BRZ, Z early only
    tbl[9]  = '{16'hEE39, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0039, 1'b0, 8'h06}; // JMP -7
    tbl[10] = '{16'hE001, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0001, 1'b0, 8'hFF}; // JMP +1 wraps
    tbl[11] = '{16'hD084, 2'b00, 2'b10, 16'h0800, 16'h0800, 16'h0004, 1'b0, 8'h00}; // BRN taken
    tbl[12] = '{16'h3298, 2'b00, 2'b00, 16'h2994, 16'h2995, 16'h0018, 1'b0, 8'h04}; // SUB
    tbl[13] = '{16'h8F3F, 2'b00, 2'b00, 16'hF048, 16'hF049, 16'h003F, 1'b0, 8'h05}; // ADI
    tbl[14] = '{16'h0FFF, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h003F, 1'b0, 8'h06}; // NOP
    tbl[15] = '{16'h9580, 2'b00, 2'b00, 16'h5802, 16'h5803, 16'h0000, 1'b0, 8'h07}; // LD
    tbl[16] = '{16'hD084, 2'b11, 2'b01, 16'h0800, 16'h0800, 16'h0004, 1'b0, 8'h08}; // BRN, N early only
    tbl[17] = '{16'h6971, 2'b00, 2'b00, 16'h9728, 16'h9729, 16'h0031, 1'b0, 8'h09}; // XOR

    // Two reset cycles; the second one's outputs are the post-reset state.
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    step(1'b0, 16'h2650, 1'b0, 1'b0, mk(16'h0, 16'h0, 1'b0, 1'b0, 8'h00));

    foreach (tbl[i]) run_vec(tbl[i]);

    // HALT at 0x0A: halted from the next cycle, PC frozen, Instr ignored.
    step(1'b1, 16'hF000, 1'b0, 1'b0, mk(16'h0, 16'h0, 1'b0, 1'b0, 8'h0A));
    repeat (3) step(1'b1, 16'h2650, 1'b1, 1'b1, mk(16'h0, 16'h0, 1'b0, 1'b1, 8'h0A));
    // Reset out of HALT.
    step(1'b0, 16'h2650, 1'b0, 1'b0, mk(16'h0, 16'h0, 1'b0, 1'b1, 8'h0A));
    // Fetch ADD, then reset during its first EXEC cycle: no RW pulse follows.
    step(1'b1, 16'h2650, 1'b0, 1'b0, mk(16'h0, 16'h0, 1'b0, 1'b0, 8'h00));
    step(1'b0, 16'h0000, 1'b0, 1'b0, mk(16'h6508, 16'h0010, 1'b0, 1'b0, 8'h00));
    // Restart from PC 0 and run the ADD through to completion.
    run_vec(tbl[0]);
    step(1'b1, 16'h0000, 1'b0, 1'b0, mk(16'h0, 16'h0, 1'b0, 1'b0, 8'h01));

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge CLK);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit that drives the datapath's 16-bit control word (CTRWRD) and constant input (Cin), and consumes the datapath status flags V, C, N, Z.
- Fetches 16-bit instructions from instruction memory and decodes them into control words.
- Holds each control word stable long enough to cover the datapath's registered B/D buses and function unit.
- Sequences PC update, branches, store strobes and halt.

Parameters:
- PC_W, 8: program counter / instruction address width.
- EX_CYC, 2: cycles each control word is held with RW=0 before the write-back cycle; legal range 1..15.
- RESET_PC, 0: PC value loaded at reset.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- Instr  in  16  instruction memory read data for Iaddr; valid combinationally.
- V, C, N, Z  in  1 each  datapath status flags.
- Iaddr  out  PC_W  instruction address (equals PC).
- CTRWRD  out  16  control word, laid out as:
  - DA = [15:13], AA = [12:10], BA = [9:7]
  - MB = [6], FS = [5:2], MD = [1], RW = [0]
- Cin  out  16  immediate, zero-extended IR[5:0].
- MW  out  1  data memory write strobe.
- Halted  out  1  high while in the HALT state.

Behaviour:
- Instruction format: op = IR[15:12], DR = IR[11:9], SA = IR[8:6], SB = IR[5:3], imm = IR[5:0].
- Branch offset: off = sign-extended 9-bit {IR[11:9], IR[5:0]}.
- Outputs are decoded only from registers (state, IR, counter); there are no combinational paths from inputs to outputs.
- States and transitions:
  - FETCH: 1 cycle. IR <= Instr. Go to HALT if op = F, else go to EXEC with cnt = 0.
  - EXEC: CTRWRD = decode(IR) with RW = 0. cnt increments; after EX_CYC cycles go to WB. On the last EXEC cycle, latch Z and N into zf/nf.
  - WB: 1 cycle. CTRWRD = decode(IR) with RW = 1 for writing ops. MW = 1 for ST only. Update PC, then go to FETCH.
  - HALT: CTRWRD = 0, MW = 0, Halted = 1, PC frozen. Exit only via reset.
- Every non-HALT instruction takes exactly EX_CYC + 2 cycles.
- Decode table (op: operation, DA/AA/BA, MB, FS, MD, writes):
  - 0 NOP: CTRWRD = 0.
  - 1 MOV: DR <- SA; FS = 0000.
  - 2 ADD: DR <- SA + SB; FS = 0010.
  - 3 SUB: DR <- SA - SB; FS = 0101.
  - 4 AND: FS = 1000.
  - 5 OR: FS = 1001.
  - 6 XOR: FS = 1010.
  - 7 NOT: DR <- ~SA; FS = 1011.
  - 8 ADI: DR <- SA + imm; MB = 1, FS = 0010, BA = 0.
  - 9 LD: DR <- M[SA]; MD = 1, FS = 0000.
  - A ST: M[SA] <- SB; AA = SA, BA = SB, DA = 0, never writes.
  - B LDI: DR <- imm; MB = 1, FS = 1100, AA = BA = 0.
  - C BRZ: AA = SA, FS = 0000, DA = BA = 0, no write; taken if zf = 1.
  - D BRN: same as BRZ; taken if nf = 1.
  - E JMP: CTRWRD = 0, always taken.
  - F HALT.
- Register ops (1-8) use DA = DR, AA = SA, BA = SB unless stated; MB = 0 and MD = 0 unless stated.
- For non-writing ops, RW = 0 in every state.
- Cin = {10'b0, IR[5:0]} in EXEC and WB; 0 otherwise.
- PC update at the end of WB: PC <= PC + off if taken, else PC + 1. Arithmetic is modulo 2^PC_W, so wrap-around is silent.
- V and C are ignored; they are reserved.
- Reset (RESET = 0 at a clock edge, in any state, including mid-EXEC or in HALT):
  - PC = RESET_PC, IR = 0, cnt = 0, zf = nf = 0, state = FETCH.
  - CTRWRD = 0, Cin = 0, MW = 0, Halted = 0.
  - No RW or MW pulse is emitted for the aborted instruction.
- Instr changing during EXEC/WB has no effect; IR is latched only in FETCH.

Test Plan (EX_CYC = 2):
- Reset: hold RESET = 0 for 2 cycles, then release -> Iaddr = 0x00, CTRWRD = 0x0000, Cin = 0, MW = 0, Halted = 0; first FETCH occurs on the next edge.
- Instr = 0x2650 (ADD R3, R1, R2) at PC 0 -> CTRWRD = 0x6508 for 2 EXEC cycles, then 0x6509 for 1 WB cycle; Iaddr = 0x01 after 4 cycles.
- Instr = 0xBA2A (LDI R5, #42) -> Cin = 0x002A; CTRWRD = 0xA070 in EXEC, 0xA071 in WB.
- Instr = 0xCE3D (BRZ R0, -3) at PC 0x05:
  - Z = 1 on the last EXEC cycle -> PC = 0x02.
  - Z = 0 -> PC = 0x06.
  - Z = 1 only on the first EXEC cycle -> not taken.
  - JMP +1 at PC 0xFF -> PC = 0x00.
- ST (0xA0D0) -> MW = 1 only in the WB cycle; RW = 0 in all cycles; AA = 3, BA = 2.
- Instr = 0xF000 -> Halted = 1 from the cycle after FETCH, Iaddr frozen. Then assert RESET during the EXEC of a following ADD -> no RW = 1 is ever seen; restart at PC 0.
